// File: rtl/common_pkg.sv
// common_pkg: shared types and widths for the memory access sequencer.
package common_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } mem_ctrl_state_t;

    // Request as latched on acceptance.
    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store sequencer placed in front of memory_1k.
// Accepts one request, issues a one-cycle read or write strobe, waits RD_LATENCY cycles
// for read data and returns a response over a valid/ready handshake.
// Optional feature: define MEM_ACCESS_FAULT_EN to answer addresses >= MEM_WORDS with a
// fault response and no memory access.
module mem_access_ctrl
    import common_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned MEM_WORDS  = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [MEM_ADDR_W-1:0] i_req_addr,
    input  logic [MEM_DATA_W-1:0] i_req_wdata,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [MEM_DATA_W-1:0] o_resp_rdata,
    output logic                  o_resp_fault,
    output logic                  o_mem_rd,
    output logic                  o_mem_wr,
    output logic [MEM_ADDR_W-1:0] o_mem_addr,
    output logic [MEM_DATA_W-1:0] o_mem_wdata,
    input  logic [MEM_DATA_W-1:0] i_mem_rdata
);

    // Wait counter start value; the read word is sampled in the cycle the count hits 0.
    localparam logic [2:0] WAIT_LOAD = (RD_LATENCY == 0) ? 3'd0 : 3'(RD_LATENCY - 1);

    mem_ctrl_state_t state;
    mem_req_t        req;
    logic [2:0]      wait_cnt;
    logic            addr_fault;

    // Ready is combinational so it drops while reset is held and rises in the first
    // cycle after release.
    assign o_req_ready = (state == ST_IDLE) && !i_rst;

    // Address and write data come from the latched request, so they hold their last
    // value outside the access cycle.
    assign o_mem_addr  = req.addr;
    assign o_mem_wdata = req.wdata;

`ifdef MEM_ACCESS_FAULT_EN
    assign addr_fault = (32'(i_req_addr) >= MEM_WORDS);
`else
    assign addr_fault   = 1'b0;
    assign o_resp_fault = 1'b0;
    // Keep MEM_WORDS referenced in builds without the fault check.
    if (MEM_WORDS == 0) begin : g_mem_words_unused
    end
`endif

    // Sequencer FSM with registered strobes and response outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            req          <= '0;
            wait_cnt     <= 3'd0;
            o_resp_valid <= 1'b0;
            o_resp_rdata <= '0;
            o_mem_rd     <= 1'b0;
            o_mem_wr     <= 1'b0;
`ifdef MEM_ACCESS_FAULT_EN
            o_resp_fault <= 1'b0;
`endif
        end else begin
            // Strobes are single-cycle pulses; only an accept re-arms them.
            o_mem_rd <= 1'b0;
            o_mem_wr <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        if (addr_fault) begin
                            // Out-of-range: answer immediately, memory untouched.
                            state        <= ST_RESP;
                            o_resp_valid <= 1'b1;
                            o_resp_rdata <= '0;
`ifdef MEM_ACCESS_FAULT_EN
                            o_resp_fault <= 1'b1;
`endif
                        end else begin
                            req      <= '{we: i_req_we, addr: i_req_addr, wdata: i_req_wdata};
                            o_mem_wr <= i_req_we;
                            o_mem_rd <= !i_req_we;
                            state    <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (req.we) begin
                        state        <= ST_RESP;
                        o_resp_valid <= 1'b1;
                        o_resp_rdata <= '0;
`ifdef MEM_ACCESS_FAULT_EN
                        o_resp_fault <= 1'b0;
`endif
                    end else if (RD_LATENCY == 0) begin
                        // Zero latency: data is valid during the strobe cycle itself.
                        state        <= ST_RESP;
                        o_resp_valid <= 1'b1;
                        o_resp_rdata <= i_mem_rdata;
`ifdef MEM_ACCESS_FAULT_EN
                        o_resp_fault <= 1'b0;
`endif
                    end else begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state        <= ST_RESP;
                        o_resp_valid <= 1'b1;
                        o_resp_rdata <= i_mem_rdata;
`ifdef MEM_ACCESS_FAULT_EN
                        o_resp_fault <= 1'b0;
`endif
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    if (i_resp_ready) begin
                        state        <= ST_IDLE;
                        o_resp_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
